// File: rtl/reg_dump_scanner.sv
// Walks an inclusive, wrapping range of register indices, reads each one through the
// register file's display port and streams (index, data) words out over a valid/ready handshake.
module reg_dump_scanner #(
  parameter bit SKIP_X0 = 1'b1
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iStart,
  input  logic        iAbort,
  input  logic [4:0]  iFirstReg,
  input  logic [4:0]  iLastReg,
  output logic [4:0]  oRegSel,
  input  logic [31:0] iRegData,
  output logic [31:0] oData,
  output logic [4:0]  oIndex,
  output logic        oValid,
  input  logic        iReady,
  output logic        oLast,
  output logic        oBusy,
  output logic        oDone
);

  typedef enum logic [1:0] {
    StIdle,
    StSel,
    StSend,
    StDone
  } state_e;

  state_e      r_state;
  logic [4:0]  r_idx;
  logic [4:0]  r_last;
  logic [31:0] r_data;
  logic [4:0]  r_index;
  logic        r_valid;
  logic        r_olast;
  logic        r_done;

  logic [4:0]  w_idx_inc;
  logic        w_skip;
  logic        w_is_last;
  logic        w_last_word;

  assign w_idx_inc = r_idx + 5'd1;
  assign w_skip    = SKIP_X0 && (r_idx == 5'd0);
  assign w_is_last = (r_idx == r_last);
  // A word is also final when the only index left after it is a skipped x0.
  assign w_last_word = w_is_last || (SKIP_X0 && (w_idx_inc == 5'd0) && (r_last == 5'd0));

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state <= StIdle;
      r_idx   <= 5'd0;
      r_last  <= 5'd0;
      r_data  <= 32'd0;
      r_index <= 5'd0;
      r_valid <= 1'b0;
      r_olast <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if ((r_state != StIdle) && iAbort) begin
        r_state <= StIdle;
        r_valid <= 1'b0;
        r_olast <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (iStart) begin
              r_idx   <= iFirstReg;
              r_last  <= iLastReg;
              r_state <= StSel;
            end
          end
          StSel: begin
            if (w_skip) begin
              if (w_is_last) begin
                r_state <= StDone;
              end else begin
                r_idx <= w_idx_inc;
              end
            end else begin
              r_data  <= iRegData;
              r_index <= r_idx;
              r_valid <= 1'b1;
              r_olast <= w_last_word;
              r_state <= StSend;
            end
          end
          StSend: begin
            if (iReady) begin
              r_valid <= 1'b0;
              r_olast <= 1'b0;
              if (w_is_last) begin
                r_state <= StDone;
              end else begin
                r_idx   <= w_idx_inc;
                r_state <= StSel;
              end
            end
          end
          StDone: begin
            r_done  <= 1'b1;
            r_state <= StIdle;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign oRegSel = r_idx;
  assign oData   = r_data;
  assign oIndex  = r_index;
  assign oValid  = r_valid;
  assign oLast   = r_olast;
  assign oBusy   = (r_state != StIdle);
  assign oDone   = r_done;

endmodule

// File: tb/tb_reg_dump_scanner.sv
// Directed bench: one scanner with x0 skipping and one without, sharing stimulus and a
// register-file model; emitted words are collected per instance and compared to hand values.
`timescale 1ns/1ps
module tb_reg_dump_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        ready = 1'b1;
  logic [4:0]  first = 5'd0;
  logic [4:0]  last = 5'd0;
  logic [31:0] regs [32];

  logic [4:0]  sel1, idx1, sel0, idx0;
  logic [31:0] rd1, rd0, data1, data0;
  logic        v1, l1, b1, d1, v0, l0, b0, d0;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
    int          cyc;
  } word_t;

  word_t q1[$];
  word_t q0[$];
  int    done1 = 0, done0 = 0, done1_cyc = 0, cyc = 0;
  int    checks = 0, failures = 0;

  always #5 clk = ~clk;

  assign rd1 = regs[sel1];
  assign rd0 = regs[sel0];

  reg_dump_scanner #(.SKIP_X0(1'b1)) u_dut1 (
    .iCLK(clk), .iRST(rst), .iStart(start), .iAbort(abort), .iFirstReg(first),
    .iLastReg(last), .oRegSel(sel1), .iRegData(rd1), .oData(data1), .oIndex(idx1),
    .oValid(v1), .iReady(ready), .oLast(l1), .oBusy(b1), .oDone(d1)
  );

  reg_dump_scanner #(.SKIP_X0(1'b0)) u_dut0 (
    .iCLK(clk), .iRST(rst), .iStart(start), .iAbort(abort), .iFirstReg(first),
    .iLastReg(last), .oRegSel(sel0), .iRegData(rd0), .oData(data0), .oIndex(idx0),
    .oValid(v0), .iReady(ready), .oLast(l0), .oBusy(b0), .oDone(d0)
  );

  // Pre-edge values are seen here, so a push marks a handshake completing on this edge.
  always @(posedge clk) begin
    if (v1 && ready) q1.push_back('{idx1, data1, l1, cyc});
    if (v0 && ready) q0.push_back('{idx0, data0, l0, cyc});
    if (d1) begin
      done1++;
      done1_cyc = cyc;
    end
    if (d0) done0++;
    cyc++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    q1.delete();
    q0.delete();
    done1 = 0;
    done0 = 0;
  endtask

  task automatic kick(input logic [4:0] f, input logic [4:0] l, output int s);
    @(negedge clk);
    first = f;
    last  = l;
    start = 1'b1;
    s     = cyc;
    @(negedge clk);
    start = 1'b0;
    first = 5'd20;
    last  = 5'd21;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((b1 || b0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 64'(n >= 300), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_valid1();
    int n = 0;
    while (!v1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("valid_timeout", 64'(n >= 50), 64'd0);
  endtask

  initial begin
    int s;
    int n;
    for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h11;
    regs[0] = 32'hDEAD_0000;

    #1 rst = 1'b1;
    #2;
    check("rst_ctrl", {v1, l1, b1, d1}, 4'b0000);
    check("rst_data", {sel1, idx1, data1}, 42'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // x0 skipped on one instance; a mid-dump iStart must be ignored.
    clear_log();
    kick(5'd0, 5'd3, s);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    check("skip_cnt", q1.size(), 3);
    if (q1.size() == 3) begin
      check("skip_w0", {q1[0].idx, q1[0].data, q1[0].last}, {5'd1, 32'h11, 1'b0});
      check("skip_w1", {q1[1].idx, q1[1].data, q1[1].last}, {5'd2, 32'h22, 1'b0});
      check("skip_w2", {q1[2].idx, q1[2].data, q1[2].last}, {5'd3, 32'h33, 1'b1});
    end
    check("skip_done", done1, 1);
    check("noskip_cnt", q0.size(), 4);
    if (q0.size() == 4) check("noskip_x0", {q0[0].idx, q0[0].data}, {5'd0, 32'hDEAD_0000});
    check("poke_idle", {b1, b0}, 2'b00);

    // Wrapping range 30..1.
    clear_log();
    kick(5'd30, 5'd1, s);
    wait_idle();
    check("wrap_cnt0", q0.size(), 4);
    if (q0.size() == 4) begin
      check("wrap_idx0", {q0[0].idx, q0[1].idx, q0[2].idx, q0[3].idx},
            {5'd30, 5'd31, 5'd0, 5'd1});
      check("wrap_last0", {q0[0].last, q0[1].last, q0[2].last, q0[3].last}, 4'b0001);
      check("wrap_data0", q0[1].data, 32'h20F);
    end
    check("wrap_cnt1", q1.size(), 3);
    if (q1.size() == 3) check("wrap_last1", {q1[1].last, q1[2].last, q1[2].idx}, {2'b01, 5'd1});

    // last=0 skipped: word at 31 must carry oLast.
    clear_log();
    kick(5'd30, 5'd0, s);
    wait_idle();
    check("lastx0_cnt1", q1.size(), 2);
    if (q1.size() == 2) check("lastx0_flag", {q1[0].last, q1[1].last, q1[1].idx}, {2'b01, 5'd31});
    check("lastx0_done", done1, 1);
    check("lastx0_cnt0", q0.size(), 3);

    // Latency and throughput.
    clear_log();
    kick(5'd5, 5'd6, s);
    wait_idle();
    check("lat_cnt", q1.size(), 2);
    if (q1.size() == 2) begin
      check("lat_first", q1[0].cyc - s, 2);
      check("lat_rate", q1[1].cyc - q1[0].cyc, 2);
      check("lat_w1", {q1[1].idx, q1[1].data, q1[1].last}, {5'd6, 32'h66, 1'b1});
    end
    check("lat_done", done1_cyc - s, 6);

    // Back-pressure for 5 cycles.
    clear_log();
    ready = 1'b0;
    kick(5'd4, 5'd5, s);
    wait_valid1();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_hold", {v1, idx1, data1}, {1'b1, 5'd4, 32'h44});
    end
    ready = 1'b1;
    wait_idle();
    check("stall_cnt", q1.size(), 2);
    if (q1.size() == 2) check("stall_w0", {q1[0].idx, q1[0].data}, {5'd4, 32'h44});

    // Abort on the second handshake of a 4-word dump.
    clear_log();
    kick(5'd8, 5'd11, s);
    n = 0;
    while (!(q1.size() == 1 && v1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("abort_timeout", 64'(n >= 50), 64'd0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_state", {b1, v1, l1}, 3'b000);
    repeat (4) @(negedge clk);
    check("abort_cnt", q1.size(), 2);
    if (q1.size() == 2) check("abort_w1", q1[1].idx, 5'd9);
    check("abort_nodone", done1, 0);

    // Range holding only skipped x0.
    clear_log();
    kick(5'd0, 5'd0, s);
    wait_idle();
    check("x0only_cnt", q1.size(), 0);
    check("x0only_done", {done1, done1_cyc - s}, {32'd1, 32'd3});

    // Reset in SEND, then a fresh dump on the first edge after release.
    clear_log();
    ready = 1'b0;
    kick(5'd12, 5'd13, s);
    wait_valid1();
    #1 rst = 1'b1;
    #1;
    check("mrst_ctrl", {v1, l1, b1, d1}, 4'b0000);
    check("mrst_data", {sel1, idx1, data1}, 42'd0);
    @(negedge clk);
    clear_log();
    ready = 1'b1;
    rst   = 1'b0;
    first = 5'd2;
    last  = 5'd3;
    start = 1'b1;
    s     = cyc;
    @(negedge clk);
    start = 1'b0;
    check("mrst_accept", b1, 1'b1);
    wait_idle();
    check("mrst_cnt", q1.size(), 2);
    if (q1.size() == 2) begin
      check("mrst_w0", {q1[0].idx, q1[0].data}, {5'd2, 32'h22});
      check("mrst_w1", {q1[1].idx, q1[1].data, q1[1].last}, {5'd3, 32'h33, 1'b1});
    end
    check("mrst_done", done1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=0", cyc);
    $fatal(1, "timeout");
  end

endmodule
